multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle main decoder. One FSM sequences fetch, decode, execute, memory and writeback over several cycles for RV32I ops R, I-ALU, load, store, branch, JAL, JALR and LUI.
- Drives every datapath select, enable and memory request.
- Adds handshaken memory with a timeout watchdog, a trap state for faults, and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready in a memory state; 0 disables the watchdog.
- RETIRE_W, 32: width of instret.
- TMO_W, 8: width of the watchdog counter; MEM_TIMEOUT must be less than 2^TMO_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode of the latched instruction register.
- mem_ready  in  1  memory has completed the current request (read data valid, or write accepted).
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier for mem_req.
- adr_src  out  1  0 = PC address, 1 = ALUOut address.
- ir_write  out  1  latch instruction and OldPC.
- pc_update  out  1  unconditional PC write.
- branch  out  2  00 none, 01 conditional (datapath gates it with the compare flag).
- reg_write  out  1  register file write.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RS1.
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- alu_op  out  2  00 add, 01 compare/sub, 10 funct-decoded, 11 address add.
- result_src  out  2  00 ALUOut, 01 ReadData, 10 ALUResult, 11 ImmExt.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- halted  out  1  FSM is in TRAP.
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- retire  out  1  one-cycle pulse when an instruction completes.
- instret  out  RETIRE_W  count of retired instructions.

Behaviour:
- Reset (asynchronous, rst_n=0): state goes to FETCH, instret=0, fault=00, watchdog=0.
- All outputs are Moore functions of state, except imm_src (a function of op in every state) and the mem_ready-qualified enables.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. On mem_ready: ir_write=1 and pc_update=1 in the same cycle, then go to DECODE. Without mem_ready, stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (precomputes the branch/JAL target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - 0110111 -> LUI
  - any other op -> TRAP with fault=01
- MEMADR: a=10, b=01, alu_op=11. Loads go to MEMREAD, stores go to MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire. Go to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready: retire, go to FETCH.
- EXEC_R: a=10, b=00, alu_op=10. Go to ALUWB.
- EXEC_I: a=10, b=01, alu_op=10. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire. Go to FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=01, retire. Go to FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Go to ALUWB.
- JALR_ADR: a=10, b=01, alu_op=00. Go to JALR.
- JALR: a=01, b=10, result_src=00, pc_update=1. Go to ALUWB.
- LUI: result_src=11, reg_write=1, retire. Go to FETCH.
- Watchdog:
  - Clears on entry to FETCH, MEMREAD and MEMWRITE; increments each cycle mem_ready=0 in those states.
  - When the count reaches MEM_TIMEOUT and mem_ready=0, go to TRAP with fault=10.
  - mem_ready in the same cycle as the limit wins: normal transition, no fault.
- TRAP: all enables 0, halted=1, fault held. Exit only via reset.
- instret increments on each retire cycle and wraps to 0 past its maximum value. retire is exactly one cycle per instruction.
- Reset mid-instruction: immediate return to FETCH. No write enable may remain asserted after reset.

Test Plan:
- ADD (op 0110011), mem_ready=1 every cycle -> states FETCH, DECODE, EXEC_R, ALUWB (4 cycles); reg_write=1 only in ALUWB; instret goes 0 to 1.
- LW (op 0000011) with MEMREAD mem_ready delayed 3 cycles -> 8 cycles total; mem_req=1 and adr_src=1 held through the wait; result_src=01 and reg_write=1 in MEMWB.
- JAL (op 1101111) -> pc_update=1 in FETCH and in JAL; ALUWB writes with result_src=00; retire pulses exactly once; imm_src=011 throughout.
- op=1111111 -> TRAP after DECODE, fault=01, halted=1; outputs stay frozen for 20 cycles; rst_n low returns to FETCH with fault=00.
- MEM_TIMEOUT=4 with mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles, fault=10. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no fault.
- RETIRE_W=4, run 17 LUI instructions (3 cycles each) -> instret wraps 15 to 0 and ends at 1.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - memory request/ready handshake between controller and memory
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM with memory watchdog, trap and retire counter
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32,
    parameter int TMO_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   mem,
    input  logic [6:0]          op,
    output logic                adr_src,
    output logic                ir_write,
    output logic                pc_update,
    output logic [1:0]          branch,
    output logic                reg_write,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          result_src,
    output logic [2:0]          imm_src,
    output logic                halted,
    output logic [1:0]          fault,
    output logic                retire,
    output logic [RETIRE_W-1:0] instret
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR_ADR = 4'd11;
    localparam logic [3:0] S_JALR     = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;

    localparam bit             WDOG_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TMO_W:0] TMO_LIMIT = (TMO_W+1)'(MEM_TIMEOUT);

    logic [3:0]       state;
    logic [3:0]       state_next;
    logic [1:0]       fault_next;
    logic [TMO_W-1:0] wdog;
    logic             mem_wait;
    logic             tmo_hit;

    assign mem_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);

    // Trip on the cycle whose miss would make the count reach the limit; ready in that cycle still wins.
    assign tmo_hit = WDOG_EN && mem_wait && !mem.mem_ready &&
                     (({1'b0, wdog} + (TMO_W+1)'(1)) == TMO_LIMIT);

    always_comb begin
        state_next = state;
        fault_next = fault;
        case (state)
            S_FETCH: begin
                if (mem.mem_ready) begin
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                    fault_next = F_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_BR:             state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR_ADR;
                    OP_LUI:            state_next = S_LUI;
                    default: begin
                        state_next = S_TRAP;
                        fault_next = F_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR:   state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem.mem_ready) begin
                    state_next = S_MEMWB;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                    fault_next = F_TIMEOUT;
                end
            end
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: begin
                if (mem.mem_ready) begin
                    state_next = S_FETCH;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                    fault_next = F_TIMEOUT;
                end
            end
            S_EXEC_R:   state_next = S_ALUWB;
            S_EXEC_I:   state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_JALR_ADR: state_next = S_JALR;
            S_JALR:     state_next = S_ALUWB;
            S_LUI:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            fault <= F_NONE;
        end else begin
            state <= state_next;
            fault <= fault_next;
        end
    end

    // Counting only while parked in the same wait state gives the clear-on-entry behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (mem_wait && !mem.mem_ready && (state_next == state)) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 1'b1;
        end
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: imm_src = 3'b000;
            OP_STORE:               imm_src = 3'b001;
            OP_BR:                  imm_src = 3'b010;
            OP_JAL:                 imm_src = 3'b011;
            OP_LUI:                 imm_src = 3'b100;
            default:                imm_src = 3'b000;
        endcase
    end

    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_update   = 1'b0;
        branch      = 2'b00;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        result_src  = 2'b00;
        retire      = 1'b0;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                ir_write    = mem.mem_ready;
                pc_update   = mem.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
            end
            S_MEMREAD: begin
                mem.mem_req = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                adr_src     = 1'b1;
                retire      = mem.mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 2'b01;
                retire    = 1'b1;
            end
            S_JAL, S_JALR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_LUI: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       adr_src, ir_write, pc_update, reg_write, halted, retire;
    logic [1:0] branch, alu_src_a, alu_src_b, alu_op, result_src, fault;
    logic [2:0] imm_src;
    logic [3:0] instret;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(4), .RETIRE_W(4), .TMO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem(bus.master), .op(op),
        .adr_src(adr_src), .ir_write(ir_write), .pc_update(pc_update),
        .branch(branch), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .imm_src(imm_src), .halted(halted), .fault(fault), .retire(retire),
        .instret(instret)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_instret = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011, ADDI = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level reference: cycle count, memory accesses and per-instruction pulse counts.
    task automatic model(input logic [6:0] o, output int base, output int nmem, output int nrw,
                         output int npc, output logic [1:0] rs_wb, output logic [2:0] imm,
                         output bit is_store, output bit is_branch);
        base = 4; nmem = 1; nrw = 1; npc = 1; rs_wb = 2'b00; imm = 3'b000;
        is_store = 0; is_branch = 0;
        case (o)
            LW:   begin base = 5; nmem = 2; rs_wb = 2'b01; end
            SW:   begin nmem = 2; nrw = 0; imm = 3'b001; is_store = 1; end
            BEQ:  begin base = 3; nrw = 0; imm = 3'b010; is_branch = 1; end
            JAL:  begin npc = 2; imm = 3'b011; end
            JALR: begin base = 5; npc = 2; end
            LUI:  begin base = 3; rs_wb = 2'b11; imm = 3'b100; end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("rst_instret", 32'(instret), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_state", {halted, bus.mem_req, adr_src, reg_write, bus.mem_we}, 5'b01000);
        exp_instret = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one legal instruction; fd/md are wait cycles for the fetch and the data access.
    task automatic run_instr(input logic [6:0] o, input int fd, input int md);
        int base, nmem, nrw, npc, exp_cyc;
        logic [1:0] rs_wb;
        logic [2:0] imm;
        bit is_store, is_branch, done, r;
        int cyc = 0, req_n = 0, wt = 0, n_rw = 0, n_pc = 0, n_we = 0, n_br = 0;
        int n_ir = 0, n_ret = 0, n_fetch = 0, n_dat = 0;
        model(o, base, nmem, nrw, npc, rs_wb, imm, is_store, is_branch);
        exp_cyc = base + fd + ((nmem == 2) ? md : 0);
        op = o;
        done = 0;
        while (!done && cyc < 40) begin
            if (bus.mem_req) begin
                if (wt < ((req_n == 0) ? fd : md)) begin
                    bus.mem_ready = 1'b0;
                    wt++;
                end else begin
                    bus.mem_ready = 1'b1;
                    wt = 0;
                    req_n++;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            check("imm_src", 32'(imm_src), 32'(imm));
            check("no_halt", {halted, fault}, 3'b000);
            if (bus.mem_req && !adr_src) begin
                n_fetch++;
                check("fetch_sel", {alu_src_a, alu_src_b, alu_op, result_src}, 8'b00_10_00_10);
            end
            if (bus.mem_req && adr_src) n_dat++;
            if (cyc == fd + 2)
                check("decode_sel", {bus.mem_req, alu_src_a, alu_src_b, alu_op}, 7'b0_01_01_00);
            if (reg_write) begin
                n_rw++;
                check("wb_result_src", 32'(result_src), 32'(rs_wb));
            end
            n_pc += int'(pc_update);
            n_we += int'(bus.mem_we);
            n_ir += int'(ir_write);
            n_br += int'(branch == 2'b01);
            r = retire;
            if (r) begin
                n_ret++;
                done = 1;
            end
            @(posedge clk);
            if (r) exp_instret = (exp_instret + 1) % 16;
            @(negedge clk);
        end
        check("cycles", cyc, exp_cyc);
        check("retires", n_ret, 1);
        check("reg_writes", n_rw, nrw);
        check("pc_updates", n_pc, npc);
        check("ir_writes", n_ir, 1);
        check("fetch_cycles", n_fetch, fd + 1);
        check("data_cycles", n_dat, (nmem == 2) ? md + 1 : 0);
        check("we_cycles", n_we, is_store ? md + 1 : 0);
        check("branch_cycles", n_br, is_branch ? 1 : 0);
        check("instret", 32'(instret), 32'(exp_instret));
    endtask

    task automatic fetch_timeout(input int ready_at);
        do_reset();
        op = LUI;
        for (int i = 1; i <= 4; i++) begin
            bus.mem_ready = (i == ready_at);
            #1;
            check("tmo_wait", {halted, bus.mem_req}, 2'b01);
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        #1;
        if (ready_at == 0) check("tmo_trap", {halted, fault, bus.mem_req}, 4'b1_10_0);
        else check("tmo_ready_wins", {halted, fault, bus.mem_req, alu_src_a, alu_src_b}, 8'b0_00_0_0101);
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] ops[8] = '{LW, SW, ADD, ADDI, BEQ, JAL, JALR, LUI};
        rst_n = 1'b0;
        op = ADD;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        run_instr(ADD, 0, 0);
        run_instr(LW, 0, 3);
        run_instr(JAL, 0, 0);
        run_instr(SW, 1, 2);

        // Illegal opcode: trap after DECODE, frozen outputs, reset recovers.
        op = 7'b1111111;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            check("trap_frozen", {halted, fault, bus.mem_req, bus.mem_we, reg_write, pc_update,
                                  ir_write, retire, branch}, 11'b1_01_000000_00);
            check("trap_instret", 32'(instret), 32'(exp_instret));
            @(negedge clk);
        end
        do_reset();
        check("post_trap_fault", 32'(fault), 0);

        fetch_timeout(0);
        fetch_timeout(4);

        // Data-read timeout: four missed ready cycles in MEMREAD.
        do_reset();
        op = LW;
        for (int i = 1; i <= 7; i++) begin
            bus.mem_ready = (i == 1);
            @(negedge clk);
        end
        #1;
        check("rd_tmo_trap", {halted, fault}, 3'b1_10);

        // Reset in the middle of a store must drop the write qualifier immediately.
        do_reset();
        op = SW;
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("store_we_on", 32'(bus.mem_we), 1);
        rst_n = 1'b0;
        #1;
        check("store_rst", {bus.mem_we, reg_write, bus.mem_req, halted}, 4'b0010);
        do_reset();

        for (int i = 0; i < 17; i++) run_instr(LUI, 0, 0);
        check("wrap_end", 32'(instret), 1);

        for (int i = 0; i < 60; i++)
            run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
